bus_load_sequencer: RTL and testbench

BUS_LOAD_SEQUENCER -- requirements
Module: bus_load_sequencer

---
 rtl/bus_pkg.sv | 64 ++++++
 rtl/load_cmd_fifo.sv | 61 ++++++
 rtl/bus_load_sequencer.sv | 154 +++++++++++++++
 tb/tb_bus_load_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus load sequencer: register select codes,
// load-enable bit positions, queued command layout and FSM states.
package bus_pkg;

    localparam int LD_W = 12;

    localparam logic [3:0] SEL_STR_PTR = 4'h1;
    localparam logic [3:0] SEL_MAR     = 4'h4;
    localparam logic [3:0] SEL_MDR     = 4'h5;
    localparam logic [3:0] SEL_PR1     = 4'h6;
    localparam logic [3:0] SEL_PR2     = 4'h7;
    localparam logic [3:0] SEL_PR3     = 4'h8;
    localparam logic [3:0] SEL_COL     = 4'h9;
    localparam logic [3:0] SEL_ROW     = 4'hA;
    localparam logic [3:0] SEL_R1      = 4'hB;
    localparam logic [3:0] SEL_R2      = 4'hC;

    localparam int LD_STR_PTR = 0;
    localparam int LD_MAR     = 3;
    localparam int LD_MDR     = 4;
    localparam int LD_PR1     = 5;
    localparam int LD_PR2     = 6;
    localparam int LD_PR3     = 7;
    localparam int LD_COL     = 8;
    localparam int LD_ROW     = 9;
    localparam int LD_R1      = 10;
    localparam int LD_R2      = 11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GAP
    } seq_state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] hold;
    } load_cmd_t;

    // Unassigned select codes decode to all-zero, which doubles as the legality test.
    function automatic logic [LD_W-1:0] sel_decode(input logic [3:0] sel);
        logic [LD_W-1:0] en;
        en = '0;
        case (sel)
            SEL_STR_PTR: en[LD_STR_PTR] = 1'b1;
            SEL_MAR:     en[LD_MAR]     = 1'b1;
            SEL_MDR:     en[LD_MDR]     = 1'b1;
            SEL_PR1:     en[LD_PR1]     = 1'b1;
            SEL_PR2:     en[LD_PR2]     = 1'b1;
            SEL_PR3:     en[LD_PR3]     = 1'b1;
            SEL_COL:     en[LD_COL]     = 1'b1;
            SEL_ROW:     en[LD_ROW]     = 1'b1;
            SEL_R1:      en[LD_R1]      = 1'b1;
            SEL_R2:      en[LD_R2]      = 1'b1;
            default:     en             = '0;
        endcase
        return en;
    endfunction

    function automatic logic sel_is_legal(input logic [3:0] sel);
        return sel_decode(sel) != '0;
    endfunction

endpackage

// File: rtl/load_cmd_fifo.sv
// Pending load-command queue: power-of-two depth, wrapping pointers,
// registered occupancy count and full/empty flags derived from it.
module load_cmd_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  load_cmd_t                push_cmd,
    input  logic                     pop,
    output load_cmd_t                head_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    load_cmd_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_cmd = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_load_sequencer.sv
// Queued register-load sequencer: IDLE/LOAD/GAP FSM driving one-hot ld_en.
// Optional macro BUS_LOAD_SEL_ERR_EN drops illegal select codes and pulses sel_err.
module bus_load_sequencer
    import bus_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [1:0]       cmd_hold,
    output logic [LD_W-1:0]  ld_en,
    output logic             busy,
    output logic             done,
    output logic             sel_err
);

    seq_state_t              state;
    seq_state_t              next_state;
    logic [3:0]              sel_q;
    logic [1:0]              hold_q;
    logic [1:0]              hold_cnt;

    load_cmd_t               push_cmd;
    load_cmd_t               head_cmd;
    logic                    q_push;
    logic                    q_pop;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(QDEPTH):0] q_count;

    logic                    load_cmd;
    logic                    drop_head;
    logic [LD_W-1:0]         ld_en_next;
    logic                    done_next;

    assign push_cmd  = '{sel: cmd_sel, hold: cmd_hold};
    assign q_push    = cmd_valid && cmd_ready;
    assign cmd_ready = !q_full;
    assign busy      = (state != IDLE) || (q_count != '0);

    load_cmd_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_cmd (push_cmd),
        .pop      (q_pop),
        .head_cmd (head_cmd),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

`ifdef BUS_LOAD_SEL_ERR_EN
    assign drop_head = !sel_is_legal(head_cmd.sel);
`else
    assign drop_head = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IDLE and GAP both pop the head; a dropped entry costs one cycle back in IDLE.
    always_comb begin
        next_state = state;
        q_pop      = 1'b0;
        load_cmd   = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    q_pop = 1'b1;
                    if (!drop_head) begin
                        load_cmd   = 1'b1;
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (hold_cnt == hold_q) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                next_state = IDLE;
                if (!q_empty) begin
                    q_pop = 1'b1;
                    if (!drop_head) begin
                        load_cmd   = 1'b1;
                        next_state = LOAD;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ld_en_next = '0;
        done_next  = 1'b0;
        if (state == LOAD) begin
            ld_en_next = sel_decode(sel_q);
        end
        if (state == GAP) begin
            done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
        end else if (load_cmd) begin
            sel_q    <= head_cmd.sel;
            hold_q   <= head_cmd.hold;
            hold_cnt <= '0;
        end else if (state == LOAD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Outputs lag the state by one register so ld_en and done are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_en <= '0;
            done  <= 1'b0;
        end else begin
            ld_en <= ld_en_next;
            done  <= done_next;
        end
    end

`ifdef BUS_LOAD_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= q_pop && drop_head;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_load_sequencer.sv
// Directed testbench for bus_load_sequencer with hand-computed expectations.
// Honours BUS_LOAD_SEL_ERR_EN for the illegal-code scenario.
module tb_bus_load_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_sel;
    logic [1:0]  cmd_hold;
    logic [11:0] ld_en;
    logic        busy;
    logic        done;
    logic        sel_err;

    int tests_run    = 0;
    int tests_failed = 0;
    bit monitor_on   = 1'b0;

    bus_load_sequencer #(
        .QDEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_hold  (cmd_hold),
        .ld_en     (ld_en),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [1:0] h);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_hold  = h;
        tick();
        cmd_valid = 1'b0;
    endtask

    // len cycles of the given enable pattern, then the single GAP cycle carrying done.
    task automatic expectPulse(input string tag, input logic [11:0] val, input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            checkOutput({tag, "_en"}, 32'(ld_en), 32'(val));
            checkOutput({tag, "_nodone"}, 32'(done), 32'd0);
        end
        tick();
        checkOutput({tag, "_gap_en"}, 32'(ld_en), 32'd0);
        checkOutput({tag, "_gap_done"}, 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (monitor_on) begin
            checkOutput("onehot0", 32'($onehot0(ld_en)), 32'd1);
            checkOutput("en_vs_done", 32'((ld_en != 12'h000) && done), 32'd0);
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = 4'h0;
        cmd_hold  = 2'd0;
        tick();
        tick();
        monitor_on = 1'b1;
        checkOutput("rst_ld_en", 32'(ld_en), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;
        tick();

        // Single MAR load, hold 0
        applyStimulus(4'b0100, 2'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_ready", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("t1_lat_en", 32'(ld_en), 32'd0);
        expectPulse("t1", 12'h008, 1);
        tick();
        checkOutput("t1_end_done", 32'(done), 32'd0);
        checkOutput("t1_end_busy", 32'(busy), 32'd0);

        // R2 load, hold 3
        applyStimulus(4'b1100, 2'd3);
        tick();
        checkOutput("t2_lat_en", 32'(ld_en), 32'd0);
        expectPulse("t2", 12'h800, 4);
        tick();
        checkOutput("t2_end_busy", 32'(busy), 32'd0);

        // Five back-to-back commands fill the queue behind a long load
        applyStimulus(4'b1100, 2'd3);
        applyStimulus(4'b0100, 2'd0);
        checkOutput("t3_b_en", 32'(ld_en), 32'd0);
        applyStimulus(4'b0100, 2'd1);
        checkOutput("t3_c_en", 32'(ld_en), 32'h800);
        applyStimulus(4'b1001, 2'd2);
        checkOutput("t3_d_en", 32'(ld_en), 32'h800);
        applyStimulus(4'b0001, 2'd0);
        checkOutput("t3_e_en", 32'(ld_en), 32'h800);
        checkOutput("t3_full_ready", 32'(cmd_ready), 32'd0);
        checkOutput("t3_full_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("t3_a_last_en", 32'(ld_en), 32'h800);
        checkOutput("t3_still_full", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("t3_a_gap_en", 32'(ld_en), 32'd0);
        checkOutput("t3_a_gap_done", 32'(done), 32'd1);
        checkOutput("t3_ready_back", 32'(cmd_ready), 32'd1);
        expectPulse("t3_b", 12'h008, 1);
        expectPulse("t3_c", 12'h008, 2);
        expectPulse("t3_d", 12'h100, 3);
        expectPulse("t3_e", 12'h001, 1);
        tick();
        checkOutput("t3_end_done", 32'(done), 32'd0);
        checkOutput("t3_end_busy", 32'(busy), 32'd0);

        // Illegal select code 0010, hold 1
        applyStimulus(4'b0010, 2'd1);
`ifdef BUS_LOAD_SEL_ERR_EN
        tick();
        checkOutput("t4_sel_err", 32'(sel_err), 32'd1);
        checkOutput("t4_en", 32'(ld_en), 32'd0);
        checkOutput("t4_done", 32'(done), 32'd0);
        tick();
        checkOutput("t4_sel_err_off", 32'(sel_err), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_no_done", 32'(done), 32'd0);
            checkOutput("t4_no_en", 32'(ld_en), 32'd0);
        end
`else
        tick();
        checkOutput("t4_lat_en", 32'(ld_en), 32'd0);
        expectPulse("t4", 12'h000, 2);
        checkOutput("t4_sel_err", 32'(sel_err), 32'd0);
        tick();
        checkOutput("t4_end_busy", 32'(busy), 32'd0);
`endif

        // Reset during the second LOAD cycle with two commands queued
        applyStimulus(4'b1100, 2'd3);
        applyStimulus(4'b0101, 2'd0);
        applyStimulus(4'b0110, 2'd0);
        checkOutput("t5_pre_en", 32'(ld_en), 32'h800);
        rst = 1'b1;
        tick();
        checkOutput("t5_rst_en", 32'(ld_en), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t5_after_en", 32'(ld_en), 32'd0);
            checkOutput("t5_after_done", 32'(done), 32'd0);
            checkOutput("t5_after_busy", 32'(busy), 32'd0);
        end

        monitor_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
